// File: rtl/wb_interconnect_slave_dec_pkg.sv
// Shared types and configuration for the Wishbone slave-side address decoder.
package wb_interconnect_slave_dec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DECERR = 2'd2,
      TOERR  = 2'd3
   } dec_state_t;

   localparam int NR_SLAVES = 4;

   // Widest address the match helper handles; narrower buses zero-extend.
   localparam int ADR_W_MAX = 64;

   function automatic logic addr_match(input logic [ADR_W_MAX-1:0] adr,
                                       input logic [ADR_W_MAX-1:0] base,
                                       input logic [ADR_W_MAX-1:0] mask);
      return ((adr ^ base) & mask) == '0;
   endfunction

endpackage

// File: rtl/wb_interconnect_slave_dec_if.sv
// Bus bundle between the granted master stream, the decoder and its S slaves.
interface wb_interconnect_slave_dec_if #(
   parameter int S  = 4,
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int SW = DW / 8;

   // Handshake: m_cyc_i frames a bus cycle, m_stb_i qualifies one beat; a beat
   // completes on the clock where stb is high and exactly one of ack/err/rty is
   // returned. Slaves answer only while their own cyc and stb bits are set.
   logic [AW-1:0]   m_adr_i;
   logic [DW-1:0]   m_dat_i;
   logic [SW-1:0]   m_sel_i;
   logic            m_we_i;
   logic            m_cyc_i;
   logic            m_stb_i;
   logic [2:0]      m_cti_i;
   logic [1:0]      m_bte_i;
   logic [DW-1:0]   m_dat_o;
   logic            m_ack_o;
   logic            m_err_o;
   logic            m_rty_o;

   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o;
   logic [SW-1:0]   s_sel_o;
   logic            s_we_o;
   logic [2:0]      s_cti_o;
   logic [1:0]      s_bte_o;
   logic [S-1:0]    s_cyc_o;
   logic [S-1:0]    s_stb_o;
   logic [S*DW-1:0] s_dat_i;
   logic [S-1:0]    s_ack_i;
   logic [S-1:0]    s_err_i;
   logic [S-1:0]    s_rty_i;

   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
      output m_dat_o, m_ack_o, m_err_o, m_rty_o,
      output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
      input  s_dat_i, s_ack_i, s_err_i, s_rty_i
   );

   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
      input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
      output s_dat_i, s_ack_i, s_err_i, s_rty_i
   );

endinterface

// File: rtl/wb_interconnect_addr_dec.sv
// Combinational address decoder: one-hot slave hit (lowest index wins) plus valid.
module wb_interconnect_addr_dec
   import wb_interconnect_slave_dec_pkg::*;
#(
   parameter int              S      = NR_SLAVES,
   parameter int              AW     = 32,
   parameter logic [S*AW-1:0] S_BASE = '0,
   parameter logic [S*AW-1:0] S_MASK = '0
) (
   input  logic [AW-1:0] adr,
   output logic [S-1:0]  hit,
   output logic          valid
);

   always_comb begin
      hit   = '0;
      valid = 1'b0;
      for (int i = 0; i < S; i++) begin
         if (!valid && addr_match(ADR_W_MAX'(adr),
                                  ADR_W_MAX'(S_BASE[i*AW +: AW]),
                                  ADR_W_MAX'(S_MASK[i*AW +: AW]))) begin
            hit[i] = 1'b1;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_interconnect_slave_dec.sv
// Wishbone B3 slave-side decoder: locks one slave per bus cycle, muxes its response.
// Optional macro WB_INTERCONNECT_DEC_TIMEOUT_EN adds the stall timeout and TOERR.
module wb_interconnect_slave_dec
   import wb_interconnect_slave_dec_pkg::*;
#(
   parameter int              S       = NR_SLAVES,
   parameter int              AW      = 32,
   parameter int              DW      = 32,
   parameter logic [S*AW-1:0] S_BASE  = '0,
   parameter logic [S*AW-1:0] S_MASK  = '0,
   parameter int              TIMEOUT = 255
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   wb_interconnect_slave_dec_if.slave   bus,
   output dec_state_t                   dbg_state
);

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("TIMEOUT must be at least 2");
   end

   logic [S-1:0]  hit;
   logic          hit_valid;
   dec_state_t    state;
   logic [S-1:0]  sel_q;
   logic          sel_ack, sel_err, sel_rty;
   logic [DW-1:0] sel_dat;

   wb_interconnect_addr_dec #(
      .S      (S),
      .AW     (AW),
      .S_BASE (S_BASE),
      .S_MASK (S_MASK)
   ) u_addr_dec (
      .adr   (bus.m_adr_i),
      .hit   (hit),
      .valid (hit_valid)
   );

   assign bus.s_adr_o = bus.m_adr_i;
   assign bus.s_dat_o = bus.m_dat_i;
   assign bus.s_sel_o = bus.m_sel_i;
   assign bus.s_we_o  = bus.m_we_i;
   assign bus.s_cti_o = bus.m_cti_i;
   assign bus.s_bte_o = bus.m_bte_i;
   assign dbg_state   = state;

   always_comb begin
      sel_ack = 1'b0;
      sel_err = 1'b0;
      sel_rty = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < S; i++) begin
         if (sel_q[i]) begin
            sel_ack = sel_ack | bus.s_ack_i[i];
            sel_err = sel_err | bus.s_err_i[i];
            sel_rty = sel_rty | bus.s_rty_i[i];
            sel_dat = sel_dat | bus.s_dat_i[i*DW +: DW];
         end
      end
   end

   // Responses only pass while the master still holds cyc; err > rty > ack.
   always_comb begin
      bus.s_cyc_o = '0;
      bus.s_stb_o = '0;
      bus.m_dat_o = '0;
      bus.m_ack_o = 1'b0;
      bus.m_err_o = 1'b0;
      bus.m_rty_o = 1'b0;
      unique case (state)
         ACTIVE: begin
            bus.s_cyc_o = sel_q & {S{bus.m_cyc_i}};
            bus.s_stb_o = sel_q & {S{bus.m_stb_i}};
            bus.m_dat_o = sel_dat;
            bus.m_err_o = bus.m_cyc_i & sel_err;
            bus.m_rty_o = bus.m_cyc_i & ~sel_err & sel_rty;
            bus.m_ack_o = bus.m_cyc_i & ~sel_err & ~sel_rty & sel_ack;
         end
         DECERR, TOERR: bus.m_err_o = 1'b1;
         default: ;
      endcase
   end

`ifdef WB_INTERCONNECT_DEC_TIMEOUT_EN
   localparam int            CW      = $clog2(TIMEOUT);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] to_cnt;
   logic [CW-1:0] to_cnt_nxt;

   assign to_cnt_nxt = to_cnt + CW'(1);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         sel_q <= '0;
`ifdef WB_INTERCONNECT_DEC_TIMEOUT_EN
         to_cnt <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.m_cyc_i && bus.m_stb_i) begin
                  if (hit_valid) begin
                     sel_q <= hit;
                     state <= ACTIVE;
                  end else begin
                     state <= DECERR;
                  end
               end
            end
            // Selection stays locked for the whole cycle; later addresses are not decoded.
            ACTIVE: begin
               if (!bus.m_cyc_i) begin
                  state <= IDLE;
                  sel_q <= '0;
`ifdef WB_INTERCONNECT_DEC_TIMEOUT_EN
                  to_cnt <= '0;
               end else if (bus.m_stb_i && !(sel_ack || sel_err || sel_rty)) begin
                  if (to_cnt_nxt == TO_LAST) begin
                     state  <= TOERR;
                     sel_q  <= '0;
                     to_cnt <= '0;
                  end else begin
                     to_cnt <= to_cnt_nxt;
                  end
               end else begin
                  to_cnt <= '0;
`endif
               end
            end
            DECERR, TOERR: state <= IDLE;
            default:       state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_interconnect_slave_dec.sv
// Self-checking bench for wb_interconnect_slave_dec: directed scenarios plus random traffic
// against a transaction-level model of the decoder.
module tb_wb_interconnect_slave_dec;
   import wb_interconnect_slave_dec_pkg::*;

   localparam int S       = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;

   localparam logic [31:0] BASE [4] = '{32'h1000_0100, 32'h1000_0000, 32'h3000_0000, 32'h3000_0000};
   localparam logic [31:0] MASK [4] = '{32'hFFFF_FF00, 32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000};
   localparam logic [S*AW-1:0] P_BASE = {BASE[3], BASE[2], BASE[1], BASE[0]};
   localparam logic [S*AW-1:0] P_MASK = {MASK[3], MASK[2], MASK[1], MASK[0]};

   // ---------------- clock / reset ----------------
   logic       clk_i = 1'b0;
   logic       rst_ni;
   dec_state_t dbg_state;

   always #5 clk_i = ~clk_i;

   wb_interconnect_slave_dec_if #(.S(S), .AW(AW), .DW(DW)) bus ();

   wb_interconnect_slave_dec #(
      .S       (S),
      .AW      (AW),
      .DW      (DW),
      .S_BASE  (P_BASE),
      .S_MASK  (P_MASK),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mdl_sel: slave owning the current bus cycle (-1 none); mdl_err: an error beat is
   // being reported this cycle; mdl_wait: stalled strobe cycles of the current beat.
   int mdl_sel  = -1;
   bit mdl_err  = 1'b0;
   int mdl_wait = 0;

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < S; i++)
         if ((a & MASK[i]) == (BASE[i] & MASK[i])) return i;
      return -1;
   endfunction

   function automatic bit answered(input int i);
      return bus.s_ack_i[i] | bus.s_err_i[i] | bus.s_rty_i[i];
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mdl_sel  = -1;
         mdl_err  = 1'b0;
         mdl_wait = 0;
      end else if (mdl_err) begin
         mdl_err = 1'b0;
      end else if (mdl_sel < 0) begin
         if (bus.m_cyc_i && bus.m_stb_i) begin
            if (decode(bus.m_adr_i) < 0) mdl_err = 1'b1;
            else begin
               mdl_sel  = decode(bus.m_adr_i);
               mdl_wait = 0;
            end
         end
      end else if (!bus.m_cyc_i) begin
         mdl_sel  = -1;
         mdl_wait = 0;
      end else if (bus.m_stb_i && !answered(mdl_sel)) begin
         mdl_wait++;
`ifdef WB_INTERCONNECT_DEC_TIMEOUT_EN
         if (mdl_wait == TIMEOUT - 1) begin
            mdl_err  = 1'b1;
            mdl_sel  = -1;
            mdl_wait = 0;
         end
`endif
      end else begin
         mdl_wait = 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_i) begin : cmp
      logic [3:0]  e_cyc, e_stb;
      logic        e_ack, e_err, e_rty;
      logic [31:0] e_dat;
      e_cyc = '0; e_stb = '0; e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0; e_dat = '0;
      if (mdl_err) begin
         e_err = 1'b1;
      end else if (mdl_sel >= 0) begin
         if (bus.m_cyc_i) e_cyc = 4'(1 << mdl_sel);
         if (bus.m_stb_i) e_stb = 4'(1 << mdl_sel);
         e_dat = bus.s_dat_i[mdl_sel*32 +: 32];
         if (bus.m_cyc_i) begin
            if (bus.s_err_i[mdl_sel])      e_err = 1'b1;
            else if (bus.s_rty_i[mdl_sel]) e_rty = 1'b1;
            else if (bus.s_ack_i[mdl_sel]) e_ack = 1'b1;
         end
      end
      check("s_cyc_o", 64'(bus.s_cyc_o), 64'(e_cyc));
      check("s_stb_o", 64'(bus.s_stb_o), 64'(e_stb));
      check("m_resp",  64'({bus.m_err_o, bus.m_rty_o, bus.m_ack_o}), 64'({e_err, e_rty, e_ack}));
      check("m_dat_o", 64'(bus.m_dat_o), 64'(e_dat));
      check("bcast",
            64'({bus.s_adr_o, bus.s_sel_o, bus.s_we_o, bus.s_cti_o, bus.s_bte_o}),
            64'({bus.m_adr_i, bus.m_sel_i, bus.m_we_i, bus.m_cti_i, bus.m_bte_i}));
      check("bcast_dat", 64'(bus.s_dat_o), 64'(bus.m_dat_i));
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_master(input logic cyc, input logic stb, input logic [31:0] adr,
                               input logic [2:0] cti);
      bus.m_cyc_i = cyc;
      bus.m_stb_i = stb;
      bus.m_adr_i = adr;
      bus.m_cti_i = cti;
      bus.m_dat_i = $urandom;
      bus.m_sel_i = 4'hF;
      bus.m_we_i  = 1'b0;
      bus.m_bte_i = 2'b00;
   endtask

   task automatic set_ack(input int i, input logic ack, input logic [31:0] dat);
      bus.s_ack_i[i]          = ack;
      bus.s_dat_i[i*32 +: 32] = dat;
   endtask

   task automatic clear_resp();
      bus.s_ack_i = '0;
      bus.s_err_i = '0;
      bus.s_rty_i = '0;
      bus.s_dat_i = '0;
   endtask

   task automatic settle();
      drive_master(1'b0, 1'b0, 32'h0, 3'b000);
      clear_resp();
      repeat (2) next_cycle();
   endtask

   function automatic logic [31:0] pick_adr();
      case ($urandom_range(0, 8))
         0: return 32'h1000_0004;
         1: return 32'h1000_00FC;
         2: return 32'h1000_0100;
         3: return 32'h1000_0180;
         4: return 32'h3000_0010;
         5: return 32'h3001_0000;
         6: return 32'h7000_0000;
         7: return 32'h2000_0000;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- directed scenarios ----------------
   task automatic test_single_read();
      drive_master(1'b1, 1'b1, 32'h1000_0004, 3'b000);
      @(negedge clk_i);
      check("rd_c0_stb", 64'(bus.s_stb_o), 64'(4'b0000));
      next_cycle();
      @(negedge clk_i);
      check("rd_c1_stb", 64'(bus.s_stb_o), 64'(4'b0010));
      check("rd_c1_ack", 64'(bus.m_ack_o), 64'(0));
      next_cycle();
      set_ack(1, 1'b1, 32'hDEAD_BEEF);
      @(negedge clk_i);
      check("rd_ack", 64'(bus.m_ack_o), 64'(1));
      check("rd_dat", 64'(bus.m_dat_o), 64'(32'hDEAD_BEEF));
      next_cycle();
      drive_master(1'b0, 1'b0, 32'h0, 3'b000);
      clear_resp();
      next_cycle();
      @(negedge clk_i);
      check("rd_back_idle", 64'(dbg_state), 64'(IDLE));
      settle();
   endtask

   task automatic test_unmapped();
      drive_master(1'b1, 1'b1, 32'h7000_0000, 3'b000);
      @(negedge clk_i);
      check("um_c0_err", 64'(bus.m_err_o), 64'(0));
      next_cycle();
      @(negedge clk_i);
      check("um_err", 64'(bus.m_err_o), 64'(1));
      check("um_cyc", 64'(bus.s_cyc_o), 64'(4'b0000));
      next_cycle();
      drive_master(1'b0, 1'b0, 32'h0, 3'b000);
      @(negedge clk_i);
      check("um_err_once", 64'(bus.m_err_o), 64'(0));
      check("um_idle", 64'(dbg_state), 64'(IDLE));
      settle();
   endtask

   task automatic test_burst();
      logic [31:0] got;
      drive_master(1'b1, 1'b1, 32'h1000_00FC, 3'b010);
      for (int b = 0; b < 4; b++) begin
         next_cycle();
         if (b > 0) drive_master(1'b1, 1'b1, 32'h1000_00FC + 32'(4 * b), (b == 3) ? 3'b011 : 3'b010);
         set_ack(1, 1'b1, 32'hB000_0000 + 32'(b));
         set_ack(0, 1'b1, 32'hBAD0_0000);
         exp_q.push_back(32'hB000_0000 + 32'(b));
         @(negedge clk_i);
         check("burst_cyc", 64'(bus.s_cyc_o), 64'(4'b0010));
         check("burst_ack", 64'(bus.m_ack_o), 64'(1));
         got = exp_q.pop_front();
         check("burst_dat", 64'(bus.m_dat_o), 64'(got));
      end
      settle();
   endtask

   task automatic test_stall();
      drive_master(1'b1, 1'b1, 32'h1000_0004, 3'b000);
`ifdef WB_INTERCONNECT_DEC_TIMEOUT_EN
      for (int c = 1; c <= 7; c++) begin
         next_cycle();
         @(negedge clk_i);
         check("to_wait_err", 64'(bus.m_err_o), 64'(0));
         check("to_wait_cyc", 64'(bus.s_cyc_o), 64'(4'b0010));
      end
      next_cycle();
      set_ack(1, 1'b1, 32'h0BAD_0BAD);
      @(negedge clk_i);
      check("to_err", 64'(bus.m_err_o), 64'(1));
      check("to_ack_ignored", 64'(bus.m_ack_o), 64'(0));
      check("to_cyc_drop", 64'(bus.s_cyc_o), 64'(4'b0000));
      check("to_state", 64'(dbg_state), 64'(TOERR));
      next_cycle();
      clear_resp();
      drive_master(1'b1, 1'b1, 32'h3001_0000, 3'b000);
      @(negedge clk_i);
      check("to_redecode_idle", 64'(dbg_state), 64'(IDLE));
      next_cycle();
      @(negedge clk_i);
      check("to_redecode_stb", 64'(bus.s_stb_o), 64'(4'b1000));
`else
      for (int c = 1; c <= 100; c++) begin
         next_cycle();
         @(negedge clk_i);
         check("stall_no_err", 64'(bus.m_err_o), 64'(0));
      end
      check("stall_cyc", 64'(bus.s_cyc_o), 64'(4'b0010));
      check("stall_state", 64'(dbg_state), 64'(ACTIVE));
`endif
      settle();
   endtask

   task automatic test_ack_race();
      drive_master(1'b1, 1'b1, 32'h1000_0004, 3'b000);
      repeat (7) next_cycle();
      set_ack(1, 1'b1, 32'h1234_5678);
      @(negedge clk_i);
      check("race_ack", 64'(bus.m_ack_o), 64'(1));
      check("race_err", 64'(bus.m_err_o), 64'(0));
      check("race_dat", 64'(bus.m_dat_o), 64'(32'h1234_5678));
      next_cycle();
      clear_resp();
      drive_master(1'b1, 1'b0, 32'h1000_0004, 3'b000);
      @(negedge clk_i);
      check("race_no_late_err", 64'(bus.m_err_o), 64'(0));
      check("race_state", 64'(dbg_state), 64'(ACTIVE));
      settle();
   endtask

   task automatic test_reset_mid();
      drive_master(1'b1, 1'b1, 32'h1000_0004, 3'b000);
      next_cycle();
      set_ack(1, 1'b1, 32'hA5A5_5A5A);
      #1;
      check("rst_pre_ack", 64'(bus.m_ack_o), 64'(1));
      rst_ni = 1'b0;
      #1;
      check("rst_async_ack", 64'(bus.m_ack_o), 64'(0));
      check("rst_async_dat", 64'(bus.m_dat_o), 64'(0));
      check("rst_async_cyc", 64'({bus.s_cyc_o, bus.s_stb_o}), 64'(0));
      check("rst_async_err", 64'({bus.m_err_o, bus.m_rty_o}), 64'(0));
      check("rst_async_state", 64'(dbg_state), 64'(IDLE));
      next_cycle();
      drive_master(1'b0, 1'b0, 32'h0, 3'b000);
      clear_resp();
      rst_ni = 1'b1;
      settle();
   endtask

   task automatic run_random(input int cycles);
      int resp_pct;
      resp_pct = 30;
      for (int n = 0; n < cycles; n++) begin
         next_cycle();
         if (n % 150 == 0) resp_pct = $urandom_range(0, 45);
         bus.m_cyc_i = ($urandom_range(0, 99) < 88);
         bus.m_stb_i = bus.m_cyc_i ? ($urandom_range(0, 99) < 75) : 1'($urandom_range(0, 1));
         bus.m_adr_i = pick_adr();
         bus.m_dat_i = $urandom;
         bus.m_sel_i = 4'($urandom_range(0, 15));
         bus.m_we_i  = 1'($urandom_range(0, 1));
         bus.m_cti_i = 3'($urandom_range(0, 7));
         bus.m_bte_i = 2'($urandom_range(0, 3));
         for (int i = 0; i < S; i++) begin
            bus.s_ack_i[i]          = ($urandom_range(0, 99) < resp_pct);
            bus.s_err_i[i]          = ($urandom_range(0, 99) < 3);
            bus.s_rty_i[i]          = ($urandom_range(0, 99) < 3);
            bus.s_dat_i[i*32 +: 32] = $urandom;
         end
      end
      settle();
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      rst_ni = 1'b1;
      drive_master(1'b0, 1'b0, 32'h0, 3'b000);
      clear_resp();
      #1 rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_resp", 64'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o}), 64'(0));
      check("reset_sel", 64'({bus.s_cyc_o, bus.s_stb_o}), 64'(0));
      check("reset_dat", 64'(bus.m_dat_o), 64'(0));
      check("reset_state", 64'(dbg_state), 64'(IDLE));
      next_cycle();
      rst_ni = 1'b1;
      settle();

      test_single_read();
      test_unmapped();
      test_burst();
      test_stall();
      test_ack_race();
      test_reset_mid();
      run_random(4000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_interconnect_slave_dec.md
Name: wb_interconnect_slave_dec

Overview:
- Slave-side (responder-end) companion to the bus round-robin arbiter.
- Takes the single granted master stream and decodes its address to one of S slaves.
- Locks the slave selection for the whole Wishbone B3 cycle, including bursts, and muxes the slave response back to the master.
- Generates a bus error for unmapped addresses and for slaves that stall beyond a timeout.

Parameters:
- S, default CONFIG.NR_SLAVES (4): number of slaves.
- AW, default 32: address width.
- DW, default 32: data width; SW = DW/8 byte selects.
- S_BASE, default all 0 (S*AW bits): base address of slave i in bits [i*AW +: AW].
- S_MASK, default all 0 (S*AW bits): compare mask of slave i; a 1 means the address bit is compared.
- TIMEOUT, default 255: maximum number of cycles a beat may wait for a response; minimum 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- m_adr_i  in  AW  master address.
- m_dat_i  in  DW  master write data.
- m_sel_i  in  SW  byte select.
- m_we_i  in  1  write enable.
- m_cyc_i  in  1  bus cycle.
- m_stb_i  in  1  strobe.
- m_cti_i  in  3  cycle type identifier.
- m_bte_i  in  2  burst type extension.
- m_dat_o  out  DW  read data, muxed from the selected slave.
- m_ack_o  out  1  acknowledge.
- m_err_o  out  1  error.
- m_rty_o  out  1  retry.
- s_adr_o  out  AW  address, broadcast to all slaves.
- s_dat_o  out  DW  write data, broadcast.
- s_sel_o  out  SW  byte select, broadcast.
- s_we_o  out  1  write enable, broadcast.
- s_cti_o  out  3  cycle type, broadcast.
- s_bte_o  out  2  burst type, broadcast.
- s_cyc_o  out  S  one-hot cycle, per slave.
- s_stb_o  out  S  one-hot strobe, per slave.
- s_dat_i  in  S*DW  slave read data.
- s_ack_i  in  S  slave acknowledge.
- s_err_i  in  S  slave error.
- s_rty_i  in  S  slave retry.

Behaviour:
- Reset values: state=IDLE, sel_q=0, timeout counter=0; s_cyc_o=0, s_stb_o=0, m_ack_o=0, m_err_o=0, m_rty_o=0, m_dat_o=0.
- Address match for slave i: ((m_adr_i ^ base_i) & mask_i)==0. When several slaves match, the lowest index wins.
- Broadcast signals are combinational pass-throughs of the master inputs.
- FSM states: IDLE, ACTIVE, DECERR, TOERR.
- IDLE:
  - m_cyc_i&m_stb_i with a match -> register one-hot sel_q, go to ACTIVE. The slave sees stb one cycle after the master raises it (1-cycle decode latency).
  - m_cyc_i&m_stb_i with no match -> DECERR.
- ACTIVE:
  - s_cyc_o = sel_q & {S{m_cyc_i}}; s_stb_o = sel_q & {S{m_stb_i}}.
  - m_ack_o, m_err_o, m_rty_o, m_dat_o are combinationally muxed from the selected slave.
  - sel_q is held until m_cyc_i falls. A new address within the same cycle is NOT re-decoded (burst lock).
  - m_cyc_i=0 -> IDLE, sel_q cleared.
- DECERR: m_err_o=1 for exactly one cycle, then IDLE. No slave sees cyc or stb.
- Timeout:
  - Counter increments each ACTIVE cycle with m_stb_i=1 and no ack/err/rty.
  - Counter clears on any response or when stb=0.
  - Counter reaching TIMEOUT-1 -> TOERR.
  - TOERR: s_cyc_o=0 (abandons the slave), m_err_o=1 for one cycle. The selected slave's response is ignored in that cycle. Then: m_cyc_i still 1 -> IDLE and the next beat is re-decoded; otherwise -> IDLE.
- Simultaneous slave ack and counter terminal value: the ack wins and the counter clears.
- Master drops m_cyc_i mid-beat: the FSM returns to IDLE next cycle; any late slave response is not forwarded.
- Reset asserted mid-cycle: all outputs take their reset values immediately (asynchronously).
- At most one of m_ack_o, m_err_o, m_rty_o is forwarded; priority err > rty > ack if a slave violates the protocol.

Optional Feature:
- Macro: WB_INTERCONNECT_DEC_TIMEOUT_EN.
- Defined: timeout counter (width $clog2(TIMEOUT)) and TOERR state present, as described above.
- Undefined: no counter and no TOERR state; a stalled slave stalls the master indefinitely. All other behaviour is unchanged.

Decomposition:
- Shared package (soc_config/soc_functions):
  - dec_state_t enum {IDLE, ACTIVE, DECERR, TOERR}.
  - NR_SLAVES and per-slave base/mask constants in CONFIG.
  - Function addr_match(adr, base, mask).
- One sub-module, wb_interconnect_addr_dec: purely combinational, m_adr_i -> one-hot match vector (lowest index wins) plus a valid flag.

Test Plan:
- Setup for all scenarios: S=4; slave1 base 0x1000_0000, mask 0xF000_0000; TIMEOUT=8.
- Single read: read at 0x1000_0004; slave1 acks with 0xDEAD_BEEF one cycle later -> s_stb_o=0010 one cycle after m_stb_i; m_dat_o=0xDEAD_BEEF with m_ack_o.
- Unmapped address: read at 0x7000_0000 -> s_cyc_o=0000; m_err_o=1 exactly one cycle; state back to IDLE.
- Burst lock: 4-beat incrementing burst (cti=010, 011 on the last beat) starting at 0x1000_00FC crossing into another slave's range -> sel_q stays 0010 for all 4 acks.
- Stalled slave: slave1 never responds -> m_err_o on cycle 8 after stb; s_cyc_o[1]=0 in the same cycle. With the macro undefined: no error after 100 cycles.
- Resets and races: rst_ni pulsed low while ACTIVE -> all outputs 0 asynchronously. Ack arriving on the terminal timeout cycle -> m_ack_o=1 and m_err_o=0.
